// File: rtl/synapse_integrator_if.sv
// Handshake and data bundle between a step controller / weight loader and
// the synaptic integrator that feeds the LIF neuron.
interface synapse_integrator_if #(
  parameter int N_INPUTS = 4,
  parameter int AW       = $clog2(N_INPUTS)
) ();
  logic                step;
  logic [N_INPUTS-1:0] spikes_in;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [7:0]          wr_data;
  logic [11:0]         current;
  logic                busy;
  logic                done;
  logic                sat;

  modport master (
    output step, spikes_in, wr_en, wr_addr, wr_data,
    input  current, busy, done, sat
  );

  modport slave (
    input  step, spikes_in, wr_en, wr_addr, wr_data,
    output current, busy, done, sat
  );
endinterface

// File: rtl/synapse_integrator.sv
// Time-multiplexed synaptic integrator: per step, decays the held current and
// adds the weight of each spiking input, one input per cycle, saturating at 4095.
module synapse_integrator #(
  parameter int N_INPUTS    = 4,
  parameter int DECAY_SHIFT = 3,
  parameter int AW          = $clog2(N_INPUTS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  synapse_integrator_if.slave  bus
);
  localparam int CUR_W = 12;
  localparam int WGT_W = 8;
  localparam int IW    = $clog2(N_INPUTS);
  localparam logic [CUR_W-1:0] CUR_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

  state_t              state, state_nxt;
  logic [WGT_W-1:0]    weight [N_INPUTS];
  logic [N_INPUTS-1:0] spk_lat;
  logic [CUR_W-1:0]    acc;
  logic [CUR_W-1:0]    current_r;
  logic [IW-1:0]       idx;
  logic                sat_lat, sat_r, busy_r, done_r;
  logic                accept, last;
  logic [CUR_W:0]      add_res;

  // Returns {clipped, result}; the 13-bit sum can only overflow into bit 12.
  function automatic logic [CUR_W:0] sat_add(input logic [CUR_W-1:0] a,
                                             input logic [WGT_W-1:0] w);
    logic [CUR_W:0] s;
    s = {1'b0, a} + {{(CUR_W-WGT_W+1){1'b0}}, w};
    if (s[CUR_W]) return {1'b1, CUR_MAX};
    return {1'b0, s[CUR_W-1:0]};
  endfunction

  function automatic logic [CUR_W-1:0] decay(input logic [CUR_W-1:0] c);
    return c - (c >> DECAY_SHIFT);
  endfunction

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = (idx == IW'(N_INPUTS-1));
    case (state)
      IDLE: begin
        if (bus.step) begin
          accept    = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM:   if (last) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign add_res = sat_add(acc, weight[idx]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spk_lat   <= '0;
      acc       <= '0;
      idx       <= '0;
      sat_lat   <= 1'b0;
      current_r <= '0;
      sat_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            spk_lat <= bus.spikes_in;
            acc     <= decay(current_r);
            idx     <= '0;
            sat_lat <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        ACCUM: begin
          if (spk_lat[idx]) begin
            acc <= add_res[CUR_W-1:0];
            if (add_res[CUR_W]) sat_lat <= 1'b1;
          end
          if (!last) idx <= idx + 1'b1;
        end
        UPDATE: begin
          current_r <= acc;
          sat_r     <= sat_lat;
          done_r    <= 1'b1;
          busy_r    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Out-of-range addresses match no entry and are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_INPUTS; k++) weight[k] <= '0;
    end else begin
      for (int k = 0; k < N_INPUTS; k++)
        if (bus.wr_en && bus.wr_addr == AW'(k)) weight[k] <= bus.wr_data;
    end
  end

  assign bus.current = current_r;
  assign bus.sat     = sat_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
endmodule

// File: tb/tb_synapse_integrator.sv
// Randomized and directed bench for synapse_integrator with a transaction-level
// reference model of the decay / weighted-sum / saturation behaviour.
module tb_synapse_integrator;
  localparam int N  = 4;
  localparam int DS = 3;
  localparam int AW = 3;

  logic clk;
  logic reset_n;

  synapse_integrator_if #(.N_INPUTS(N), .AW(AW)) bus ();

  synapse_integrator #(.N_INPUTS(N), .DECAY_SHIFT(DS), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int          m_phase;
  int          m_acc;
  int          m_cur;
  bit          m_sat, m_satl, m_done, m_busy;
  int          m_w [N];
  logic [N-1:0] m_spk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = -1; m_acc = 0; m_cur = 0; m_sat = 0; m_satl = 0;
    m_done = 0; m_busy = 0; m_spk = '0;
    for (int k = 0; k < N; k++) m_w[k] = 0;
  endtask

  // Advance one clock edge, update the model with the inputs seen at that edge,
  // and compare all outputs.
  task automatic edge_chk();
    logic         s, we;
    logic [N-1:0] sp;
    int           wa, wd, sum;
    s = bus.step; sp = bus.spikes_in; we = bus.wr_en;
    wa = int'(bus.wr_addr); wd = int'(bus.wr_data);
    @(posedge clk); #1;
    if (!reset_n) begin
      model_reset();
    end else begin
      m_done = 0;
      if (m_phase < 0) begin
        if (s) begin
          m_spk   = sp;
          m_acc   = m_cur - m_cur / (1 << DS);
          m_satl  = 0;
          m_phase = 0;
          m_busy  = 1;
        end
      end else if (m_phase < N) begin
        if (m_spk[m_phase]) begin
          sum = m_acc + m_w[m_phase];
          if (sum > 4095) begin m_acc = 4095; m_satl = 1; end
          else m_acc = sum;
        end
        m_phase++;
      end else begin
        m_cur = m_acc; m_sat = m_satl; m_done = 1; m_busy = 0; m_phase = -1;
      end
      if (we && wa < N) m_w[wa] = wd;
    end
    check("current", 32'(bus.current), 32'(m_cur));
    check("sat",     32'(bus.sat),     32'(m_sat));
    check("busy",    32'(bus.busy),    32'(m_busy));
    check("done",    32'(bus.done),    32'(m_done));
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) edge_chk();
  endtask

  task automatic wr(input int a, input int d);
    bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_data = 8'(d);
    edge_chk();
    bus.wr_en = 1'b0;
  endtask

  // Issue one step from IDLE and wait (bounded) for done.
  task automatic run_step(input logic [N-1:0] spk);
    int lat;
    bus.spikes_in = spk; bus.step = 1'b1;
    edge_chk();
    bus.step = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      edge_chk();
      if (bus.done) begin lat = i; break; end
    end
    check("latency", 32'(lat), 32'd5);
  endtask

  // Asserts reset between edges, checks outputs clear immediately, releases later.
  task automatic mid_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_current", 32'(bus.current), 32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_done",    32'(bus.done),    32'd0);
    check("rst_sat",     32'(bus.sat),     32'd0);
    edge_chk();
    #3 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, first, second, c;
    bus.step = 1'b0; bus.spikes_in = '0; bus.wr_en = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0;
    model_reset();
    reset_n = 1'b1;
    @(posedge clk); #1;
    mid_reset();

    // Weights are zero after reset
    run_step('1);
    check("zero_weights", 32'(bus.current), 32'd0);

    // Single input
    wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 40);
    run_step(4'b0100);
    check("single_1", 32'(bus.current), 32'd30);
    check("single_1_sat", 32'(bus.sat), 32'd0);
    run_step(4'b0100);
    check("single_2", 32'(bus.current), 32'd57);

    // Saturation then pure decay
    for (int k = 0; k < N; k++) wr(k, 255);
    for (int i = 0; i < 12; i++) begin
      run_step('1);
      if (bus.sat) break;
    end
    check("sat_cur", 32'(bus.current), 32'd4095);
    check("sat_flag", 32'(bus.sat), 32'd1);
    run_step('0);
    check("decay_1", 32'(bus.current), 32'd3584);
    check("decay_1_sat", 32'(bus.sat), 32'd0);
    run_step('0);
    check("decay_2", 32'(bus.current), 32'd3136);

    // Step while busy is dropped
    bus.spikes_in = '0;
    bus.step = 1'b1; edge_chk();
    bus.step = 1'b0; edge_chk();
    bus.step = 1'b1; edge_chk();
    bus.step = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin edge_chk(); if (bus.done) ndone++; end
    check("busy_step_dones", 32'(ndone), 32'd1);

    // Held step: one update every N+2 cycles
    bus.step = 1'b1; first = -1; second = -1;
    for (int i = 0; i < 20; i++) begin
      edge_chk();
      if (bus.done) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    bus.step = 1'b0;
    check("held_period", 32'(second - first), 32'd6);
    edges(8);

    // Write collision with the input being processed
    mid_reset();
    wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 40);
    bus.spikes_in = 4'b0100; bus.step = 1'b1;
    edge_chk();
    bus.step = 1'b0;
    edge_chk(); edge_chk();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 8'd100;
    edge_chk();
    bus.wr_en = 1'b0;
    edges(3);
    check("collide_old", 32'(bus.current), 32'd30);
    run_step(4'b0100);
    check("collide_new", 32'(bus.current), 32'd127);
    wr(5, 77);
    run_step('1);
    check("oob_write", 32'(bus.current), 32'd282);

    // Reset in the middle of accumulation
    bus.spikes_in = '1; bus.step = 1'b1;
    edge_chk();
    bus.step = 1'b0;
    edge_chk(); edge_chk();
    mid_reset();
    ndone = 0;
    for (int i = 0; i < 8; i++) begin edge_chk(); if (bus.done) ndone++; end
    check("abort_dones", 32'(ndone), 32'd0);
    check("abort_current", 32'(bus.current), 32'd0);
    run_step('1);
    check("abort_weights", 32'(bus.current), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.step      = ($urandom % 3) == 0;
      bus.spikes_in = N'($urandom);
      bus.wr_en     = ($urandom % 4) == 0;
      bus.wr_addr   = AW'($urandom % 8);
      bus.wr_data   = 8'($urandom);
      if ((i % 200) == 199) mid_reset();
      else edge_chk();
    end
    bus.step = 1'b0; bus.wr_en = 1'b0;
    c = 0;
    for (int i = 0; i < 10; i++) begin edge_chk(); if (!bus.busy) c++; end
    check("drain_idle", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
